// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: access size encodings,
// FSM state type and the alignment check helper.
package mau_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WAIT = 3'd2,
      WR   = 3'd3,
      RESP = 3'd4
   } mau_state_t;

   // Halfwords need an even address, words need a 4-byte aligned address.
   function automatic logic mau_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      if (size == SZ_H && addr_lo[0])
         mis = 1'b1;
      if (size == SZ_W && addr_lo != 2'b00)
         mis = 1'b1;
      return mis;
   endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Byte-lane steering for the memory access unit (little-endian).
// Load path: pick the addressed byte/half out of a bus word and extend it.
// Store path: merge the right-justified store data into the addressed
// lane(s) of the old word, leaving the other bytes untouched.
module mau_lane_align
   import mau_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        sgn,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Load extract and zero/sign extension; words pass through unchanged.
   always_comb begin
      lane_b    = 8'h00;
      lane_h    = 16'h0000;
      load_data = word;
      case (addr_lo)
         2'd0:    lane_b = word[7:0];
         2'd1:    lane_b = word[15:8];
         2'd2:    lane_b = word[23:16];
         default: lane_b = word[31:24];
      endcase
      lane_h = addr_lo[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_B:    load_data = {{24{sgn & lane_b[7]}}, lane_b};
         SZ_H:    load_data = {{16{sgn & lane_h[15]}}, lane_h};
         default: load_data = word;
      endcase
   end

   // Store merge of the low wdata lane(s) into the previously read word.
   always_comb begin
      merged = word;
      case (size)
         SZ_B: begin
            case (addr_lo)
               2'd0:    merged[7:0]   = wdata[7:0];
               2'd1:    merged[15:8]  = wdata[7:0];
               2'd2:    merged[23:16] = wdata[7:0];
               default: merged[31:24] = wdata[7:0];
            endcase
         end
         SZ_H: begin
            if (addr_lo[1])
               merged[31:16] = wdata[15:0];
            else
               merged[15:0] = wdata[15:0];
         end
         SZ_W:    merged = wdata;
         default: merged = word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side initiator for the virtual memory bus. Accepts one byte/half/word
// load or store at a time and turns it into word-wide bus cycles, covering
// the one-cycle synchronous read latency of the memory behind the bus.
//
// Build option MAU_RMW_EN: when defined, byte/half stores are performed as a
// read-modify-write (RD -> WAIT -> WR). When undefined, byte/half stores are
// rejected with resp_err and never reach the bus; sub-word loads still work.
//
// Handshake: a request is taken on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, so exactly one
// request is in flight and req_* is ignored until the next IDLE. Completion
// is a single-cycle resp_valid pulse carrying resp_rdata/resp_err.
//
// Bus outputs are registered and loaded on the edge that enters the bus
// state, so addressVirt is on the bus during RD and wEnVirt is high for
// exactly the WR cycle. dataOutVirt is sampled in WAIT.
module mem_access_unit
   import mau_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] addressVirt,
   output logic [31:0] dataInVirt,
   output logic        wEnVirt,
   output logic        rstVirt,
   input  logic [31:0] dataOutVirt
);

`ifdef MAU_RMW_EN
   localparam logic RMW_EN = 1'b1;
`else
   localparam logic RMW_EN = 1'b0;
`endif

   mau_state_t  state;
   logic [1:0]  a_lo;
   logic [1:0]  a_size;
   logic        a_sgn;
   logic        a_we;
   logic [31:0] a_wdata;
   logic        req_err;
   logic [31:0] load_data;
   logic [31:0] merged;

   assign rstVirt   = reset;
   assign req_ready = (state == IDLE);

   // Classify the incoming request: bad alignment, reserved size, or a
   // sub-word store when read-modify-write is not built in.
   always_comb begin
      req_err = mau_misaligned(req_size, req_addr[1:0]) | (req_size == 2'b11);
      if (!RMW_EN && req_we && (req_size == SZ_B || req_size == SZ_H))
         req_err = 1'b1;
   end

   mau_lane_align u_lane_align (
      .word      (dataOutVirt),
      .addr_lo   (a_lo),
      .size      (a_size),
      .sgn       (a_sgn),
      .wdata     (a_wdata),
      .load_data (load_data),
      .merged    (merged)
   );

   // Request FSM with registered bus and response outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         a_lo        <= 2'b00;
         a_size      <= SZ_B;
         a_sgn       <= 1'b0;
         a_we        <= 1'b0;
         a_wdata     <= 32'h0;
         resp_valid  <= 1'b0;
         resp_err    <= 1'b0;
         resp_rdata  <= 32'h0;
         addressVirt <= 32'h0;
         dataInVirt  <= 32'h0;
         wEnVirt     <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         wEnVirt    <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  a_lo    <= req_addr[1:0];
                  a_size  <= req_size;
                  a_sgn   <= req_signed;
                  a_we    <= req_we;
                  a_wdata <= req_wdata;
                  if (req_err) begin
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'h0;
                     state      <= RESP;
                  end else if (req_we && req_size == SZ_W) begin
                     addressVirt <= {req_addr[31:2], 2'b00};
                     dataInVirt  <= req_wdata;
                     wEnVirt     <= 1'b1;
                     state       <= WR;
                  end else begin
                     addressVirt <= {req_addr[31:2], 2'b00};
                     state       <= RD;
                  end
               end
            end
            RD: begin
               state <= WAIT;
            end
            WAIT: begin
               if (a_we) begin
                  dataInVirt <= merged;
                  wEnVirt    <= 1'b1;
                  state      <= WR;
               end else begin
                  resp_rdata <= load_data;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end
            end
            WR: begin
               resp_rdata <= 32'h0;
               resp_valid <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a table of single requests with
// hand-computed results, then hold-valid and reset-during-write sequences.
// A small synchronous-read memory model sits on the virtual bus.
module tb_mem_access_unit;
   import mau_pkg::*;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] addressVirt;
   logic [31:0] dataInVirt;
   logic        wEnVirt;
   logic        rstVirt;
   logic [31:0] dataOutVirt;

   logic [31:0] mem [0:511];
   logic        pre_we;
   logic [8:0]  pre_idx;
   logic [31:0] pre_data;

   int total;
   int passed;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          nwr;
      logic [31:0] wr_data;
   } vec_t;

   vec_t tbl [16];

   mem_access_unit dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_size    (req_size),
      .req_signed  (req_signed),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .resp_err    (resp_err),
      .addressVirt (addressVirt),
      .dataInVirt  (dataInVirt),
      .wEnVirt     (wEnVirt),
      .rstVirt     (rstVirt),
      .dataOutVirt (dataOutVirt)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // synchronous-read memory on the virtual bus, plus a preload port
   always @(posedge clk) begin
      if (pre_we)
         mem[pre_idx] <= pre_data;
      else if (wEnVirt)
         mem[addressVirt[10:2]] <= dataInVirt;
      dataOutVirt <= mem[addressVirt[10:2]];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp)
         passed++;
      else
         $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic preload(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      pre_we   = 1'b1;
      pre_idx  = addr[10:2];
      pre_data = data;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic sg,
                               input logic [31:0] a, input logic [31:0] wd, input logic e,
                               input logic [31:0] rd, input int lt, input int nw,
                               input logic [31:0] wdat);
      vec_t v;
      v.we = we; v.size = sz; v.sgn = sg; v.addr = a; v.wdata = wd;
      v.err = e; v.rdata = rd; v.lat = lt; v.nwr = nw; v.wr_data = wdat;
      return v;
   endfunction

   // driver: present one request, follow it to resp_valid (bounded)
   task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit hold,
                         output int lat, output logic err, output logic [31:0] rdata,
                         output int nwr, output int wr_k, output logic [31:0] wr_a,
                         output logic [31:0] wr_d, output logic [31:0] rd_a,
                         output logic [31:0] resp_a, output bit ready_bad,
                         output bit ready_after);
      lat = 0; err = 1'bx; rdata = 'x; nwr = 0; wr_k = 0; wr_a = 'x; wr_d = 'x;
      rd_a = 'x; resp_a = 'x; ready_bad = 0; ready_after = 0;
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (hold)
            req_addr = addr + 32'(4 * k);
         else
            req_valid = 1'b0;
         if (k == 1)
            rd_a = addressVirt;
         if (wEnVirt) begin
            nwr++;
            wr_k = k;
            wr_a = addressVirt;
            wr_d = dataInVirt;
         end
         if (resp_valid) begin
            lat    = k;
            err    = resp_err;
            rdata  = resp_rdata;
            resp_a = addressVirt;
            break;
         end
         if (req_ready)
            ready_bad = 1;
      end
      req_valid = 1'b0;
      @(negedge clk);
      ready_after = req_ready;
   endtask

   initial begin
      int lat, nwr, wr_k;
      logic err;
      logic [31:0] rdata, wr_a, wr_d, rd_a, resp_a, last_bus, exp_300;
      bit ready_bad, ready_after, saw_resp, saw_wen;
      vec_t v;

      total = 0; passed = 0;
      reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_W;
      req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      pre_we = 1'b0; pre_idx = 9'h0; pre_data = 32'h0;

      #2 reset = 1'b1;
      #1;
      chk("rst_ready", {31'b0, req_ready}, 32'h1);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
      chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_address", addressVirt, 32'h0);
      chk("rst_datain", dataInVirt, 32'h0);
      chk("rst_wen", {31'b0, wEnVirt}, 32'h0);
      chk("rst_rstvirt", {31'b0, rstVirt}, 32'h1);

      preload(32'h000, 32'h0);
      preload(32'h100, 32'h8899AABB);
      preload(32'h300, 32'h11223344);
      preload(32'h500, 32'h55667788);
      @(negedge clk);
      reset = 1'b0;
      chk("rstvirt_low", {31'b0, rstVirt}, 32'h0);

      // we, size, sgn, addr, wdata, err, rdata, lat, nwr, wr_data
      tbl[0]  = mk(0, SZ_B, 1, 32'h101, 32'h0, 0, 32'hFFFFFFAA, 3, 0, 32'h0);
      tbl[1]  = mk(0, SZ_B, 0, 32'h101, 32'h0, 0, 32'h000000AA, 3, 0, 32'h0);
      tbl[2]  = mk(0, SZ_H, 1, 32'h102, 32'h0, 0, 32'hFFFF8899, 3, 0, 32'h0);
      tbl[3]  = mk(0, SZ_H, 0, 32'h100, 32'h0, 0, 32'h0000AABB, 3, 0, 32'h0);
      tbl[4]  = mk(0, SZ_B, 1, 32'h103, 32'h0, 0, 32'hFFFFFF88, 3, 0, 32'h0);
      tbl[5]  = mk(0, SZ_B, 1, 32'h100, 32'h0, 0, 32'hFFFFFFBB, 3, 0, 32'h0);
      tbl[6]  = mk(1, SZ_W, 0, 32'h200, 32'hDEADBEEF, 0, 32'h0, 2, 1, 32'hDEADBEEF);
      tbl[7]  = mk(0, SZ_W, 1, 32'h200, 32'h0, 0, 32'hDEADBEEF, 3, 0, 32'h0);
      tbl[8]  = mk(0, SZ_W, 0, 32'h401, 32'h0, 1, 32'h0, 1, 0, 32'h0);
      tbl[9]  = mk(0, 2'b11, 0, 32'h400, 32'h0, 1, 32'h0, 1, 0, 32'h0);
      tbl[10] = mk(0, SZ_H, 1, 32'h101, 32'h0, 1, 32'h0, 1, 0, 32'h0);
`ifdef MAU_RMW_EN
      tbl[11] = mk(1, SZ_H, 0, 32'h302, 32'h1234ABCD, 0, 32'h0, 4, 1, 32'hABCD3344);
      tbl[12] = mk(0, SZ_H, 1, 32'h302, 32'h0, 0, 32'hFFFFABCD, 3, 0, 32'h0);
      tbl[13] = mk(1, SZ_B, 0, 32'h500, 32'hFFFFFF5A, 0, 32'h0, 4, 1, 32'h5566775A);
      tbl[14] = mk(0, SZ_W, 0, 32'h500, 32'h0, 0, 32'h5566775A, 3, 0, 32'h0);
      exp_300 = 32'hABCD3344;
`else
      tbl[11] = mk(1, SZ_H, 0, 32'h302, 32'h1234ABCD, 1, 32'h0, 1, 0, 32'h0);
      tbl[12] = mk(0, SZ_H, 1, 32'h302, 32'h0, 0, 32'h00001122, 3, 0, 32'h0);
      tbl[13] = mk(1, SZ_B, 0, 32'h500, 32'hFFFFFF5A, 1, 32'h0, 1, 0, 32'h0);
      tbl[14] = mk(0, SZ_W, 0, 32'h500, 32'h0, 0, 32'h55667788, 3, 0, 32'h0);
      exp_300 = 32'h11223344;
`endif
      tbl[15] = mk(1, 2'b11, 0, 32'h300, 32'hFFFFFFFF, 1, 32'h0, 1, 0, 32'h0);

      last_bus = 32'h0;
      for (int i = 0; i < 16; i++) begin
         v = tbl[i];
         do_req(v.we, v.size, v.sgn, v.addr, v.wdata, 0, lat, err, rdata, nwr, wr_k,
                wr_a, wr_d, rd_a, resp_a, ready_bad, ready_after);
         chk($sformatf("v%0d_lat", i), lat, v.lat);
         chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, v.err});
         chk($sformatf("v%0d_rdata", i), rdata, v.rdata);
         chk($sformatf("v%0d_nwr", i), nwr, v.nwr);
         chk($sformatf("v%0d_ready_busy", i), {31'b0, ready_bad}, 32'h0);
         chk($sformatf("v%0d_ready_after", i), {31'b0, ready_after}, 32'h1);
         if (v.nwr == 1) begin
            chk($sformatf("v%0d_wr_cycle", i), wr_k, v.lat - 1);
            chk($sformatf("v%0d_wr_addr", i), wr_a, {v.addr[31:2], 2'b00});
            chk($sformatf("v%0d_wr_data", i), wr_d, v.wr_data);
         end
         if (v.err) begin
            chk($sformatf("v%0d_addr_hold", i), resp_a, last_bus);
         end else begin
            if (!(v.we && v.size == SZ_W))
               chk($sformatf("v%0d_rd_addr", i), rd_a, {v.addr[31:2], 2'b00});
            last_bus = {v.addr[31:2], 2'b00};
         end
      end
      chk("mem_500_final", mem[9'h140], tbl[14].rdata);

      // hold req_valid with a wandering address: only the first is taken
      do_req(0, SZ_W, 0, 32'h100, 32'h0, 1, lat, err, rdata, nwr, wr_k,
             wr_a, wr_d, rd_a, resp_a, ready_bad, ready_after);
      chk("hold_lat", lat, 3);
      chk("hold_rdata", rdata, 32'h8899AABB);
      chk("hold_rd_addr", rd_a, 32'h100);
      chk("hold_ready_busy", {31'b0, ready_bad}, 32'h0);
      chk("hold_nwr", nwr, 0);

      // reset during the write cycle: write dropped, no response
      @(negedge clk);
      req_valid = 1'b1;
`ifdef MAU_RMW_EN
      req_we = 1'b1; req_size = SZ_B; req_addr = 32'h300; req_wdata = 32'h77;
`else
      req_we = 1'b1; req_size = SZ_W; req_addr = 32'h300; req_wdata = 32'h77777777;
`endif
      @(posedge clk);
      saw_wen = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (wEnVirt) begin
            saw_wen = 1;
            break;
         end
      end
      chk("rmw_reached_wr", {31'b0, saw_wen}, 32'h1);
      reset = 1'b1;
      #1;
      chk("rst_wen_drop", {31'b0, wEnVirt}, 32'h0);
      chk("rst_midop_ready", {31'b0, req_ready}, 32'h1);
      saw_resp = 0;
      @(negedge clk);
      if (resp_valid) saw_resp = 1;
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (resp_valid) saw_resp = 1;
      end
      chk("rst_no_resp", {31'b0, saw_resp}, 32'h0);
      chk("rst_mem_unchanged", mem[9'h0C0], exp_300);
      chk("rst_ready_after", {31'b0, req_ready}, 32'h1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
